// File: rtl/nfca_pkg.sv
// nfca_pkg: CRC_A constants, status-byte bit positions and read-FSM states
// shared by the NFC-A RX framer and CRC logic.
package nfca_pkg;
    localparam logic [15:0] CRC_A_INIT = 16'h6363;
    localparam logic [15:0] CRC_A_POLY = 16'h8408;
    localparam int ST_TERR   = 4;
    localparam int ST_CRC_OK = 5;
    localparam int ST_OVF    = 6;
    typedef enum logic [1:0] {IDLE, LEN, DATA, STAT} rd_state_t;
endpackage

// File: rtl/nfca_crc_a.sv
// nfca_crc_a: combinational CRC_A update over one full byte, LSB first,
// reflected polynomial; shared by RX checking and TX generation.
module nfca_crc_a
    import nfca_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);
    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc ^ {8'h00, i_data};
        for (int i = 0; i < 8; i++)
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC_A_POLY) : (w_c >> 1);
    end

    assign o_crc = w_c;
endmodule

// File: rtl/nfca_rx_framer.sv
// nfca_rx_framer: ping-pong frame capture with CRC_A check, drained as length/payload/status.
// Define NFCA_RX_FRAMER_STRIP_CRC_EN to drop the two CRC bytes from frames whose CRC is good.
module nfca_rx_framer
    import nfca_pkg::*;
#(
    parameter int ASIZE = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx_tvalid,
    input  logic [7:0]       rx_tdata,
    input  logic [3:0]       rx_tdatab,
    input  logic             rx_tend,
    input  logic             rx_terr,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [7:0]       o_tdata,
    output logic             o_tlast,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int DEPTH = 2 ** ASIZE;

    logic [7:0]       r_mem [2*DEPTH];
    logic [7:0]       r_rdata;
    logic [ASIZE:0]   r_len [2];
    logic [15:0]      r_crc [2];
    logic [3:0]       r_datab [2];
    logic [1:0]       r_full, r_terr, r_ok, r_ovf, r_all8;
    logic             r_wb, r_rb, r_drop;
    logic [CNT_W-1:0] r_drop_cnt;
    rd_state_t        r_state, w_state_nxt;
    logic [ASIZE:0]   r_ptr, w_ptr_nxt;

    logic             w_beat, w_rel, w_wrel, w_acc, w_wr, w_store, w_full8, w_ok;
    logic             w_all8_b, w_ovf_b, w_all8_n, w_ovf_n;
    logic [ASIZE:0]   w_len_b, w_len_n, w_olen;
    logic [15:0]      w_crc_b, w_crc_upd, w_crc_n;
    logic [3:0]       w_datab_b, w_datab_n;
    logic [7:0]       w_stat;

    // A bank drained this cycle may be refilled this cycle, so write-side
    // values start from the cleared state in that case.
    assign w_beat    = rx_tvalid & ~rx_tend;
    assign w_rel     = (r_state == STAT) & o_tready;
    assign w_wrel    = w_rel & (r_rb == r_wb);
    assign w_acc     = ~(r_full[r_wb] & ~w_wrel) & ~r_drop;
    assign w_wr      = rx_tvalid & w_acc;
    assign w_len_b   = w_wrel ? '0 : r_len[r_wb];
    assign w_crc_b   = w_wrel ? CRC_A_INIT : r_crc[r_wb];
    assign w_all8_b  = w_wrel | r_all8[r_wb];
    assign w_ovf_b   = ~w_wrel & r_ovf[r_wb];
    assign w_datab_b = w_wrel ? 4'h0 : r_datab[r_wb];
    assign w_full8   = rx_tdatab == 4'd8;
    assign w_store   = w_beat & ~w_len_b[ASIZE];
    assign w_len_n   = w_len_b + (ASIZE+1)'(w_store);
    assign w_crc_n   = (w_store & w_full8) ? w_crc_upd : w_crc_b;
    assign w_all8_n  = w_all8_b & ~(w_store & ~w_full8);
    assign w_ovf_n   = w_ovf_b | (w_beat & w_len_b[ASIZE]);
    assign w_datab_n = w_beat ? rx_tdatab : w_datab_b;
    assign w_ok      = (w_crc_b == 16'h0000) & (w_len_b >= (ASIZE+1)'(3)) & w_all8_b & ~w_ovf_b;
    assign drop_cnt  = r_drop_cnt;

    nfca_crc_a u_crc (
        .i_crc  (w_crc_b),
        .i_data (rx_tdata),
        .o_crc  (w_crc_upd)
    );

`ifdef NFCA_RX_FRAMER_STRIP_CRC_EN
    assign w_olen = r_ok[r_rb] ? r_len[r_rb] - (ASIZE+1)'(2) : r_len[r_rb];
`else
    assign w_olen = r_len[r_rb];
`endif

    assign w_ptr_nxt = (r_state == DATA) ? r_ptr + (ASIZE+1)'(o_tready) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                r_len[b]   <= '0;
                r_crc[b]   <= CRC_A_INIT;
                r_datab[b] <= 4'h0;
            end
            r_full     <= '0;
            r_terr     <= '0;
            r_ok       <= '0;
            r_ovf      <= '0;
            r_all8     <= '1;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr && r_wb == 1'(b)) begin
                    r_len[b]   <= w_len_n;
                    r_crc[b]   <= w_crc_n;
                    r_all8[b]  <= w_all8_n;
                    r_ovf[b]   <= w_ovf_n;
                    r_datab[b] <= w_datab_n;
                    r_full[b]  <= rx_tend;
                    r_terr[b]  <= rx_tend & rx_terr;
                    r_ok[b]    <= rx_tend & w_ok;
                end else if (w_rel && r_rb == 1'(b)) begin
                    r_len[b]   <= '0;
                    r_crc[b]   <= CRC_A_INIT;
                    r_all8[b]  <= 1'b1;
                    r_ovf[b]   <= 1'b0;
                    r_datab[b] <= 4'h0;
                    r_full[b]  <= 1'b0;
                    r_terr[b]  <= 1'b0;
                    r_ok[b]    <= 1'b0;
                end
            end
            if (w_wr && rx_tend)
                r_wb <= ~r_wb;
            // Once a frame hits a full bank, the rest of it is discarded too.
            if (rx_tvalid && !w_acc) begin
                r_drop <= ~rx_tend;
                if (rx_tend && !(&r_drop_cnt))
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_rel)
                r_rb <= ~r_rb;
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && w_store)
            r_mem[{r_wb, w_len_b[ASIZE-1:0]}] <= rx_tdata;
        r_rdata <= r_mem[{r_rb, w_ptr_nxt[ASIZE-1:0]}];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = r_full[r_rb] ? LEN : IDLE;
            LEN:  w_state_nxt = !o_tready ? LEN : (w_olen == '0) ? STAT : DATA;
            DATA: w_state_nxt = (o_tready && r_ptr + (ASIZE+1)'(1) == w_olen) ? STAT : DATA;
            STAT: w_state_nxt = o_tready ? IDLE : STAT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_stat = {4'h0, r_datab[r_rb]};
        w_stat[ST_TERR]   = r_terr[r_rb];
        w_stat[ST_CRC_OK] = r_ok[r_rb];
        w_stat[ST_OVF]    = r_ovf[r_rb];
        o_tvalid = r_state != IDLE;
        o_tlast  = r_state == STAT;
        o_tdata  = (r_state == LEN)  ? 8'(w_olen) :
                   (r_state == DATA) ? r_rdata :
                   (r_state == STAT) ? w_stat : 8'h00;
    end
endmodule
